// File: rtl/change_dispenser.sv
// Coin dispenser: pays out a change amount greedily as single-cycle pulses
// on co10/co5/co1 while tracking a finite inventory of each coin.
module change_dispenser #(
  parameter int W        = 6,
  parameter int INV_W    = 4,
  parameter int INIT_N1  = 15,
  parameter int INIT_N5  = 15,
  parameter int INIT_N10 = 15,
  parameter int GAP      = 1
) (
  input  logic             clk,
  input  logic             res,
  input  logic             start,
  input  logic [W-1:0]     amount,
  input  logic             refill,
  output logic             ready,
  output logic             co1,
  output logic             co5,
  output logic             co10,
  output logic             done,
  output logic             err,
  output logic [W-1:0]     remain,
  output logic [INV_W-1:0] n1,
  output logic [INV_W-1:0] n5,
  output logic [INV_W-1:0] n10
);

  typedef enum logic [2:0] {
    IDLE, SEL, PULSE, WAIT, DONE, ERR
  } state_t;

  localparam int CW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int GAP_M1 = (GAP > 0) ? GAP - 1 : 0;

  localparam logic [CW-1:0]    GAP_LD = CW'(GAP_M1);
  localparam logic [INV_W-1:0] I1     = INV_W'(INIT_N1);
  localparam logic [INV_W-1:0] I5     = INV_W'(INIT_N5);
  localparam logic [INV_W-1:0] I10    = INV_W'(INIT_N10);
  localparam logic [W-1:0]     ONE    = W'(1);
  localparam logic [W-1:0]     FIVE   = W'(5);
  localparam logic [W-1:0]     TEN    = W'(10);

  state_t state, state_nx;

  logic [CW-1:0]    cnt, cnt_nx;
  logic [W-1:0]     remain_nx;
  logic [INV_W-1:0] n1_nx, n5_nx, n10_nx;
  logic             co1_nx, co5_nx, co10_nx;
  logic             done_nx, err_nx;

  assign ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (res) begin
      state  <= IDLE;
      cnt    <= '0;
      remain <= '0;
      n1     <= I1;
      n5     <= I5;
      n10    <= I10;
      co1    <= 1'b0;
      co5    <= 1'b0;
      co10   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      remain <= remain_nx;
      n1     <= n1_nx;
      n5     <= n5_nx;
      n10    <= n10_nx;
      co1    <= co1_nx;
      co5    <= co5_nx;
      co10   <= co10_nx;
      done   <= done_nx;
      err    <= err_nx;
    end
  end

  // Coin and counter updates land on the edge entering PULSE.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    remain_nx = remain;
    n1_nx     = n1;
    n5_nx     = n5;
    n10_nx    = n10;
    co1_nx    = 1'b0;
    co5_nx    = 1'b0;
    co10_nx   = 1'b0;
    done_nx   = 1'b0;
    err_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (refill) begin
          n1_nx  = I1;
          n5_nx  = I5;
          n10_nx = I10;
        end else if (start) begin
          remain_nx = amount;
          state_nx  = SEL;
        end
      end
      SEL: begin
        if (remain == '0) begin
          done_nx  = 1'b1;
          state_nx = DONE;
        end else if (remain >= TEN && n10 != '0) begin
          remain_nx = remain - TEN;
          n10_nx    = n10 - 1'b1;
          co10_nx   = 1'b1;
          state_nx  = PULSE;
        end else if (remain >= FIVE && n5 != '0) begin
          remain_nx = remain - FIVE;
          n5_nx     = n5 - 1'b1;
          co5_nx    = 1'b1;
          state_nx  = PULSE;
        end else if (n1 != '0) begin
          remain_nx = remain - ONE;
          n1_nx     = n1 - 1'b1;
          co1_nx    = 1'b1;
          state_nx  = PULSE;
        end else begin
          err_nx   = 1'b1;
          state_nx = ERR;
        end
      end
      PULSE: begin
        if (GAP > 0) begin
          cnt_nx   = GAP_LD;
          state_nx = WAIT;
        end else begin
          state_nx = SEL;
        end
      end
      WAIT: begin
        if (cnt == '0) state_nx = SEL;
        else cnt_nx = cnt - 1'b1;
      end
      DONE:    state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: expected coin/done/err events are
// queued at stimulus time and matched against the pulses as they appear.
module tb_change_dispenser;

  logic       clk;
  logic       res;
  logic       start_a  [3];
  logic [5:0] amount_a [3];
  logic       refill_a [3];
  logic       ready_a  [3];
  logic       co1_a    [3];
  logic       co5_a    [3];
  logic       co10_a   [3];
  logic       done_a   [3];
  logic       err_a    [3];
  logic [5:0] remain_a [3];
  logic [3:0] n1_a     [3];
  logic [3:0] n5_a     [3];
  logic [3:0] n10_a    [3];

  typedef struct {
    int code;
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  int  total;
  int  passes;

  change_dispenser u0 (
    .clk(clk), .res(res), .start(start_a[0]), .amount(amount_a[0]),
    .refill(refill_a[0]), .ready(ready_a[0]), .co1(co1_a[0]),
    .co5(co5_a[0]), .co10(co10_a[0]), .done(done_a[0]), .err(err_a[0]),
    .remain(remain_a[0]), .n1(n1_a[0]), .n5(n5_a[0]), .n10(n10_a[0])
  );

  change_dispenser #(.INIT_N10(0)) u1 (
    .clk(clk), .res(res), .start(start_a[1]), .amount(amount_a[1]),
    .refill(refill_a[1]), .ready(ready_a[1]), .co1(co1_a[1]),
    .co5(co5_a[1]), .co10(co10_a[1]), .done(done_a[1]), .err(err_a[1]),
    .remain(remain_a[1]), .n1(n1_a[1]), .n5(n5_a[1]), .n10(n10_a[1])
  );

  change_dispenser #(.INIT_N1(2), .INIT_N5(0), .INIT_N10(0)) u2 (
    .clk(clk), .res(res), .start(start_a[2]), .amount(amount_a[2]),
    .refill(refill_a[2]), .ready(ready_a[2]), .co1(co1_a[2]),
    .co5(co5_a[2]), .co10(co10_a[2]), .done(done_a[2]), .err(err_a[2]),
    .remain(remain_a[2]), .n1(n1_a[2]), .n5(n5_a[2]), .n10(n10_a[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic push(input int code, input int cyc);
    ev_t e;
    e.code = code;
    e.cyc  = cyc;
    exp_q.push_back(e);
  endtask

  function automatic int ev_code(input int u);
    if (co10_a[u]) return 10;
    if (co5_a[u])  return 5;
    if (co1_a[u])  return 1;
    if (done_a[u]) return 100;
    if (err_a[u])  return 200;
    return 0;
  endfunction

  function automatic int nhigh(input int u);
    return int'(co1_a[u]) + int'(co5_a[u]) + int'(co10_a[u])
         + int'(done_a[u]) + int'(err_a[u]);
  endfunction

  // Accept at edge 0, then match events by cycle number until done/err.
  task automatic go(input int u, input logic [5:0] amt,
                    input int inj, input int budget);
    int  c;
    int  code;
    bit  fin;
    ev_t e;
    start_a[u]  = 1'b1;
    amount_a[u] = amt;
    step();
    start_a[u]  = 1'b0;
    amount_a[u] = 6'd63;
    c   = 1;
    fin = 1'b0;
    while (!fin && c <= budget) begin
      chk("onehot", nhigh(u) <= 1, 1);
      code = ev_code(u);
      if (code != 0) begin
        if (exp_q.size() == 0) begin
          chk("extra_event", code, 0);
        end else begin
          e = exp_q.pop_front();
          chk("ev_code", code, e.code);
          chk("ev_cycle", c, e.cyc);
        end
        if (code >= 100) fin = 1'b1;
      end
      if (c == inj) begin
        start_a[u]  = 1'b1;
        amount_a[u] = 6'd30;
      end
      step();
      start_a[u] = 1'b0;
      c++;
    end
    chk("terminated", fin, 1);
    chk("queue_empty", exp_q.size(), 0);
    exp_q.delete();
    chk("ready_after", ready_a[u], 1);
  endtask

  initial begin
    total  = 0;
    passes = 0;
    res    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_a[i]  = 1'b0;
      amount_a[i] = '0;
      refill_a[i] = 1'b0;
    end
    step();
    step();
    res = 1'b0;

    chk("rst_ready", ready_a[0], 1);
    chk("rst_remain", remain_a[0], 0);
    chk("rst_n1", n1_a[0], 15);
    chk("rst_n5", n5_a[0], 15);
    chk("rst_n10", n10_a[0], 15);
    chk("rst_pulses", nhigh(0), 0);
    chk("rst_u2_n1", n1_a[2], 2);

    // 16 = 10 + 5 + 1
    push(10, 2); push(5, 5); push(1, 8); push(100, 11);
    go(0, 6'd16, -1, 40);
    chk("a16_n10", n10_a[0], 14);
    chk("a16_n5", n5_a[0], 14);
    chk("a16_n1", n1_a[0], 14);
    chk("a16_remain", remain_a[0], 0);

    push(100, 2);
    go(0, 6'd0, -1, 10);
    chk("a0_n10", n10_a[0], 14);
    chk("a0_n5", n5_a[0], 14);
    chk("a0_n1", n1_a[0], 14);

    // no 10s available: four 5s
    push(5, 2); push(5, 5); push(5, 8); push(5, 11); push(100, 14);
    go(1, 6'd20, -1, 40);
    chk("n10z_n5", n5_a[1], 11);
    chk("n10z_n10", n10_a[1], 0);
    chk("n10z_remain", remain_a[1], 0);

    // runs out of 1s with 1 still owed
    push(1, 2); push(1, 5); push(200, 8);
    go(2, 6'd3, -1, 40);
    chk("short_remain", remain_a[2], 1);
    chk("short_n1", n1_a[2], 0);

    // start with amount 30 during the first PULSE must be ignored
    push(5, 2); push(1, 5); push(1, 8); push(100, 11);
    go(0, 6'd7, 2, 40);
    chk("a7_remain", remain_a[0], 0);
    chk("a7_n5", n5_a[0], 13);
    chk("a7_n1", n1_a[0], 12);
    chk("a7_n10", n10_a[0], 14);

    refill_a[0] = 1'b1;
    start_a[0]  = 1'b1;
    amount_a[0] = 6'd5;
    step();
    refill_a[0] = 1'b0;
    start_a[0]  = 1'b0;
    chk("refill_n5", n5_a[0], 15);
    chk("refill_n1", n1_a[0], 15);
    chk("refill_n10", n10_a[0], 15);
    chk("refill_ready", ready_a[0], 1);
    step();
    chk("refill_no_pulse", nhigh(0), 0);

    // reset lands during the first PULSE of a 25 payout
    start_a[0]  = 1'b1;
    amount_a[0] = 6'd25;
    step();
    start_a[0] = 1'b0;
    step();
    chk("mid_co10", co10_a[0], 1);
    chk("mid_n10", n10_a[0], 14);
    chk("mid_remain", remain_a[0], 15);
    res = 1'b1;
    step();
    res = 1'b0;
    chk("mres_pulses", nhigh(0), 0);
    chk("mres_ready", ready_a[0], 1);
    chk("mres_remain", remain_a[0], 0);
    chk("mres_n10", n10_a[0], 15);
    chk("mres_n5", n5_a[0], 15);
    chk("mres_n1", n1_a[0], 15);
    for (int i = 0; i < 12; i++) begin
      step();
      chk("mres_quiet", nhigh(0), 0);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
